// File: rtl/vmem_pkg.sv
// -----------------------------------------------------------------------------
// vmem_pkg
// Shared types and defaults for the frame-memory arbiter.
//   state_t : arbiter FSM states
//   req_t   : requester identity used for round-robin fairness
//   DEF_*   : default address/data widths and interrupt pulse length
// -----------------------------------------------------------------------------
package vmem_pkg;

  localparam int DEF_AW      = 15;
  localparam int DEF_DW      = 16;
  localparam int DEF_IRQ_LEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    VID_WR,
    HRD,
    HRD_CAP,
    HWR,
    HOST_DONE
  } state_t;

  typedef enum logic {
    REQ_VID,
    REQ_HOST
  } req_t;

endpackage

// File: rtl/vmem_sync2.sv
// -----------------------------------------------------------------------------
// vmem_sync2
// Two-flop synchroniser, W bits wide. Flops reset to all ones so that
// active-low strobes read as inactive straight out of reset.
// Ports:
//   clk_llc2 : destination clock
//   resetx   : asynchronous active-low reset
//   d        : asynchronous input bits
//   q        : synchronised output bits
// -----------------------------------------------------------------------------
module vmem_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_llc2,
  input  logic         resetx,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  always_ff @(posedge clk_llc2 or negedge resetx) begin
    if (!resetx) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/vmem_arbiter.sv
// -----------------------------------------------------------------------------
// vmem_arbiter
// Owns the single-port frame RAM, arbitrating between the video write stream
// and the asynchronous host bus, flipping the ping-pong write bank at frame
// end and pulsing one frame-ready interrupt per completed bank.
// Ports:
//   clk_llc2, resetx                  : clock, async active-low reset
//   vid_req/vid_adr/vid_data/vid_ack  : video write handshake
//   vid_frame_end                     : last pixel of frame requested
//   host_csx/host_rdx/host_wrx        : async active-low host strobes
//   host_adr/host_wdata/host_rdata    : host address and data
//   host_waitx                        : active-low host wait
//   irq0/irq1                         : frame-ready pulses for bank 0/1
//   mem_adr/mem_wdata/mem_wren/mem_rden/mem_q : RAM port
// -----------------------------------------------------------------------------
module vmem_arbiter
  import vmem_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int IRQ_LEN = DEF_IRQ_LEN
) (
  input  logic          clk_llc2,
  input  logic          resetx,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_adr,
  input  logic [DW-1:0] vid_data,
  output logic          vid_ack,
  input  logic          vid_frame_end,
  input  logic          host_csx,
  input  logic          host_rdx,
  input  logic          host_wrx,
  input  logic [AW-1:0] host_adr,
  input  logic [DW-1:0] host_wdata,
  output logic [DW-1:0] host_rdata,
  output logic          host_waitx,
  output logic          irq0,
  output logic          irq1,
  output logic [AW:0]   mem_adr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  output logic          mem_rden,
  input  logic [DW-1:0] mem_q
);

  localparam logic [2:0] IRQ_LOAD = 3'(IRQ_LEN);

  logic          csx_s, rdx_s, wrx_s;
  logic          hrd, hwr;
  state_t        state_reg, state_next;
  req_t          rr_last_reg, rr_last_next;
  logic          wr_bank_reg;
  logic          hbank_reg, hbank_next;
  logic          done_reg, done_next;
  logic [DW-1:0] host_rdata_reg, host_rdata_next;
  logic [2:0]    irq_cnt_reg;
  logic          irq_sel_reg;
  logic          host_req, grant_vid, grant_host;

  vmem_sync2 #(.W(3)) u_sync (
    .clk_llc2 (clk_llc2),
    .resetx   (resetx),
    .d        ({host_csx, host_rdx, host_wrx}),
    .q        ({csx_s, rdx_s, wrx_s})
  );

  assign hrd = ~csx_s & ~rdx_s;
  assign hwr = ~csx_s & ~wrx_s;

  // Wait is released as soon as the access is done. The reset term keeps
  // the host from stalling on an access that reset has discarded.
  assign host_waitx = host_csx | done_reg | ~resetx;
  assign host_rdata = host_rdata_reg;

  // ---------------------------------------------------------------- FSM regs
  always_ff @(posedge clk_llc2 or negedge resetx) begin
    if (!resetx) begin
      state_reg      <= IDLE;
      rr_last_reg    <= REQ_HOST;
      hbank_reg      <= 1'b0;
      done_reg       <= 1'b0;
      host_rdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      rr_last_reg    <= rr_last_next;
      hbank_reg      <= hbank_next;
      done_reg       <= done_next;
      host_rdata_reg <= host_rdata_next;
    end
  end

  // ------------------------------------------------- next state and outputs
  always_comb begin
    state_next      = state_reg;
    rr_last_next    = rr_last_reg;
    hbank_next      = hbank_reg;
    done_next       = done_reg;
    host_rdata_next = host_rdata_reg;
    host_req        = 1'b0;
    grant_vid       = 1'b0;
    grant_host      = 1'b0;
    vid_ack         = 1'b0;
    mem_wren        = 1'b0;
    mem_rden        = 1'b0;
    mem_adr         = '0;
    mem_wdata       = '0;

    case (state_reg)
      IDLE: begin
        host_req = hrd | hwr;
        // Video wins when alone, or when both wait and the host went last.
        grant_vid  = vid_req & (~host_req | (rr_last_reg == REQ_HOST));
        grant_host = host_req & ~grant_vid;
        if (grant_vid) begin
          state_next   = VID_WR;
          rr_last_next = REQ_VID;
        end else if (grant_host) begin
          rr_last_next = REQ_HOST;
          // Host bank is frozen here so a frame flip cannot retarget it.
          hbank_next   = ~wr_bank_reg;
          state_next   = hrd ? HRD : HWR;
        end
      end
      VID_WR: begin
        mem_wren   = 1'b1;
        mem_adr    = {wr_bank_reg, vid_adr};
        mem_wdata  = vid_data;
        vid_ack    = 1'b1;
        state_next = IDLE;
      end
      HRD: begin
        mem_rden   = 1'b1;
        mem_adr    = {hbank_reg, host_adr};
        state_next = HRD_CAP;
      end
      HRD_CAP: begin
        host_rdata_next = mem_q;
        done_next       = 1'b1;
        state_next      = HOST_DONE;
      end
      HWR: begin
        mem_wren   = 1'b1;
        mem_adr    = {hbank_reg, host_adr};
        mem_wdata  = host_wdata;
        done_next  = 1'b1;
        state_next = HOST_DONE;
      end
      HOST_DONE: begin
        // Hold here until the host drops its strobe so one strobe is one access.
        if (!hrd && !hwr) begin
          done_next  = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------ banks and interrupt
  always_ff @(posedge clk_llc2 or negedge resetx) begin
    if (!resetx) begin
      wr_bank_reg <= 1'b0;
      irq_cnt_reg <= 3'd0;
      irq_sel_reg <= 1'b0;
    end else if (vid_frame_end) begin
      wr_bank_reg <= ~wr_bank_reg;
      // A new frame end restarts the pulse on the newly completed bank.
      irq_sel_reg <= wr_bank_reg;
      irq_cnt_reg <= IRQ_LOAD;
    end else if (irq_cnt_reg != 3'd0) begin
      irq_cnt_reg <= irq_cnt_reg - 3'd1;
    end
  end

  assign irq0 = (irq_cnt_reg != 3'd0) & ~irq_sel_reg;
  assign irq1 = (irq_cnt_reg != 3'd0) &  irq_sel_reg;

endmodule

// File: tb/tb_vmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vmem_arbiter
// Self-checking bench for vmem_arbiter: a behavioural RAM, a reference
// memory image keyed by full address, directed scenarios and a random mix of
// video writes, host reads/writes and frame ends.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vmem_arbiter;

  localparam int AW = 15;
  localparam int DW = 16;
  localparam int IRQ_LEN = 2;

  logic          clk = 1'b0;
  logic          resetx;
  logic          vid_req;
  logic [AW-1:0] vid_adr;
  logic [DW-1:0] vid_data;
  logic          vid_ack;
  logic          vid_frame_end;
  logic          host_csx, host_rdx, host_wrx;
  logic [AW-1:0] host_adr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic          host_waitx;
  logic          irq0, irq1;
  logic [AW:0]   mem_adr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wren, mem_rden;
  logic [DW-1:0] mem_q;

  // backdoor preload port into the behavioural RAM
  logic          bd_we;
  logic [AW:0]   bd_adr;
  logic [DW-1:0] bd_data;

  int checks = 0;
  int errors = 0;

  // reference model: memory image and current video bank
  bit [15:0] ref_mem [int];
  bit        ref_bank;

  vmem_arbiter #(.AW(AW), .DW(DW), .IRQ_LEN(IRQ_LEN)) dut (
    .clk_llc2      (clk),
    .resetx        (resetx),
    .vid_req       (vid_req),
    .vid_adr       (vid_adr),
    .vid_data      (vid_data),
    .vid_ack       (vid_ack),
    .vid_frame_end (vid_frame_end),
    .host_csx      (host_csx),
    .host_rdx      (host_rdx),
    .host_wrx      (host_wrx),
    .host_adr      (host_adr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .host_waitx    (host_waitx),
    .irq0          (irq0),
    .irq1          (irq1),
    .mem_adr       (mem_adr),
    .mem_wdata     (mem_wdata),
    .mem_wren      (mem_wren),
    .mem_rden      (mem_rden),
    .mem_q         (mem_q)
  );

  always #37 clk = ~clk;

  bit [DW-1:0] ram [0:(1<<(AW+1))-1];
  always @(posedge clk) begin
    if (bd_we) ram[bd_adr] <= bd_data;
    if (mem_wren) ram[mem_adr] <= mem_wdata;
    if (mem_rden) mem_q <= ram[mem_adr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit [15:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
  endfunction

  task automatic preload(input logic [AW:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_adr = a; bd_data = d;
    step();
    bd_we = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  task automatic vid_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int exp_lat);
    int lat = 0;
    bit got = 0;
    vid_req = 1'b1; vid_adr = a; vid_data = d;
    while (!got && lat < 40) begin
      @(negedge clk);
      if (vid_ack === 1'b1) got = 1;
      else begin step(); lat++; end
    end
    chk("vid_timeout", 32'(got), 1);
    if (got) begin
      chk("vid_wren", 32'(mem_wren), 1);
      chk("vid_adr", 32'(mem_adr), 32'({ref_bank, a}));
      chk("vid_wdata", 32'(mem_wdata), 32'(d));
      if (exp_lat >= 0) chk("vid_latency", lat, exp_lat);
      ref_mem[int'({ref_bank, a})] = d;
    end
    $display("vid write  adr=%h data=%h bank=%0d lat=%0d", a, d, ref_bank, lat);
    step();
    vid_req = 1'b0;
    @(negedge clk);
    chk("vid_ack_pulse", 32'(vid_ack), 0);
    step();
  endtask

  task automatic host_release();
    host_csx = 1'b1; host_rdx = 1'b1; host_wrx = 1'b1;
    repeat (3) step();
  endtask

  task automatic host_read(input logic [AW-1:0] a, input int exp_cyc);
    int cyc = 0;
    bit got = 0;
    bit [15:0] exp_d;
    logic [AW:0] exp_a;
    exp_a = {~ref_bank, a};
    exp_d = ref_rd(int'(exp_a));
    host_adr = a; host_csx = 1'b0; host_rdx = 1'b0;
    #1;
    chk("hrd_wait_low", 32'(host_waitx), 0);
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (mem_rden === 1'b1) chk("hrd_mem_adr", 32'(mem_adr), 32'(exp_a));
      if (host_waitx === 1'b1) got = 1;
      else begin step(); cyc++; end
    end
    chk("hrd_timeout", 32'(got), 1);
    if (exp_cyc >= 0) chk("hrd_latency", cyc, exp_cyc);
    chk("hrd_data", 32'(host_rdata), 32'(exp_d));
    $display("host read  adr=%h bank=%0d data=%h cyc=%0d", a, exp_a[AW], host_rdata, cyc);
    step();
    @(negedge clk);
    chk("hrd_hold_data", 32'(host_rdata), 32'(exp_d));
    chk("hrd_hold_wait", 32'(host_waitx), 1);
    step();
    host_release();
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int cyc = 0;
    bit got = 0;
    bit seen = 0;
    logic [AW:0] exp_a;
    exp_a = {~ref_bank, a};
    host_adr = a; host_wdata = d; host_csx = 1'b0; host_wrx = 1'b0;
    #1;
    chk("hwr_wait_low", 32'(host_waitx), 0);
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (mem_wren === 1'b1) begin
        seen = 1;
        chk("hwr_mem_adr", 32'(mem_adr), 32'(exp_a));
        chk("hwr_mem_wdata", 32'(mem_wdata), 32'(d));
      end
      if (host_waitx === 1'b1) got = 1;
      else begin step(); cyc++; end
    end
    chk("hwr_timeout", 32'(got), 1);
    chk("hwr_seen", 32'(seen), 1);
    ref_mem[int'(exp_a)] = d;
    $display("host write adr=%h bank=%0d data=%h cyc=%0d", a, exp_a[AW], d, cyc);
    step();
    host_release();
  endtask

  task automatic chk_irq(input bit e0, input bit e1);
    @(negedge clk);
    chk("irq0", 32'(irq0), 32'(e0));
    chk("irq1", 32'(irq1), 32'(e1));
  endtask

  task automatic frame_end_op();
    bit b;
    b = ref_bank;
    vid_frame_end = 1'b1;
    step();
    vid_frame_end = 1'b0;
    ref_bank = ~ref_bank;
    for (int k = 0; k < IRQ_LEN; k++) begin
      chk_irq(b == 1'b0, b == 1'b1);
      step();
    end
    chk_irq(1'b0, 1'b0);
    $display("frame end  completed bank=%0d", b);
    step();
  endtask

  // Host read and video write made pending in the same IDLE cycle.
  task automatic contend(input bit exp_host_first);
    int first = -1;
    bit vdone = 0, hdone = 0;
    logic [AW-1:0] ha, va;
    logic [DW-1:0] vd;
    bit [15:0] exp_d;
    ha = 15'h0005; va = 15'h0006; vd = 16'($urandom);
    exp_d = ref_rd(int'({~ref_bank, ha}));
    host_adr = ha; host_csx = 1'b0; host_rdx = 1'b0;
    step(); step();
    vid_req = 1'b1; vid_adr = va; vid_data = vd;
    for (int i = 0; i < 40 && !(vdone && hdone); i++) begin
      @(negedge clk);
      if (vid_ack === 1'b1) begin
        if (first < 0) first = 0;
        vdone = 1;
        chk("cont_vid_adr", 32'(mem_adr), 32'({ref_bank, va}));
        ref_mem[int'({ref_bank, va})] = vd;
      end
      if (mem_rden === 1'b1 && first < 0) first = 1;
      if (host_waitx === 1'b1 && !hdone) begin
        hdone = 1;
        chk("cont_hrd_data", 32'(host_rdata), 32'(exp_d));
      end
      step();
      if (vdone) vid_req = 1'b0;
      if (hdone) begin host_csx = 1'b1; host_rdx = 1'b1; end
    end
    chk("cont_timeout", 32'(vdone && hdone), 1);
    chk("cont_order", first, exp_host_first ? 1 : 0);
    $display("contention first=%s", first == 1 ? "host" : "video");
    host_release();
  endtask

  initial begin
    logic [AW-1:0] a;
    resetx = 1'b0;
    vid_req = 1'b0; vid_adr = '0; vid_data = '0; vid_frame_end = 1'b0;
    host_csx = 1'b1; host_rdx = 1'b1; host_wrx = 1'b1;
    host_adr = '0; host_wdata = '0;
    bd_we = 1'b0; bd_adr = '0; bd_data = '0;
    ref_bank = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vid_ack", 32'(vid_ack), 0);
    chk("rst_rdata", 32'(host_rdata), 0);
    chk("rst_waitx", 32'(host_waitx), 1);
    chk("rst_irq0", 32'(irq0), 0);
    chk("rst_irq1", 32'(irq1), 0);
    chk("rst_mem_wren", 32'(mem_wren), 0);
    chk("rst_mem_rden", 32'(mem_rden), 0);
    chk("rst_mem_adr", 32'(mem_adr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    step();
    resetx = 1'b1;
    step();

    // video only
    vid_write(15'h0010, 16'hA5A5, 1);

    // host read from bank 1 while video writes bank 0
    preload(16'h8020, 16'h1234);
    host_read(15'h0020, 5);

    // contention: last served host -> video first; then video last -> host first
    contend(1'b0);
    vid_write(15'h0011, 16'h5A5A, 1);
    contend(1'b1);

    // frame end on bank 0, then video writes land in bank 1
    frame_end_op();
    vid_write(15'h0010, 16'h0F0F, 1);

    // frame end during an active pulse restarts it on the other line
    begin
      bit b;
      b = ref_bank;
      vid_frame_end = 1'b1; step(); vid_frame_end = 1'b0;
      chk_irq(b == 1'b0, b == 1'b1);
      step();
      vid_frame_end = 1'b1;
      chk_irq(b == 1'b0, b == 1'b1);
      step();
      vid_frame_end = 1'b0;
      for (int k = 0; k < IRQ_LEN; k++) begin
        chk_irq(b == 1'b1, b == 1'b0);
        step();
      end
      chk_irq(1'b0, 1'b0);
      $display("frame end  restart during pulse, final bank=%0d", b);
      step();
    end

    // bank flip in the HRD cycle: data comes from the bank latched at grant
    begin
      bit old_bank;
      old_bank = ref_bank;
      preload({~old_bank, 15'h0030}, 16'hBEEF);
      preload({old_bank, 15'h0030}, 16'hCAFE);
      host_adr = 15'h0030; host_csx = 1'b0; host_rdx = 1'b0;
      step(); step(); step();
      vid_frame_end = 1'b1;
      @(negedge clk);
      chk("flip_rden", 32'(mem_rden), 1);
      chk("flip_adr", 32'(mem_adr), 32'({~old_bank, 15'h0030}));
      step();
      vid_frame_end = 1'b0;
      ref_bank = ~ref_bank;
      repeat (6) begin
        @(negedge clk);
        if (host_waitx !== 1'b1) step();
      end
      chk("flip_wait", 32'(host_waitx), 1);
      chk("flip_data", 32'(host_rdata), 32'h0000BEEF);
      $display("host read  across bank flip data=%h", host_rdata);
      step();
      host_release();
    end

    // make wr_bank=1 so reset back to 0 is observable
    if (ref_bank == 1'b0) frame_end_op();

    // reset asserted during HOST_DONE, with a pending video request
    begin
      int cyc = 0;
      host_adr = 15'h0010; host_csx = 1'b0; host_rdx = 1'b0;
      while (cyc < 20) begin
        @(negedge clk);
        if (host_waitx === 1'b1) cyc = 20; else begin step(); cyc++; end
      end
      chk("rstmid_pre_data", 32'(host_rdata), 32'(ref_rd(int'({~ref_bank, 15'h0010}))));
      step();
      resetx = 1'b0;
      vid_req = 1'b1; vid_adr = 15'h0044; vid_data = 16'h7777;
      #1;
      chk("rstmid_waitx", 32'(host_waitx), 1);
      chk("rstmid_rdata", 32'(host_rdata), 0);
      chk("rstmid_irq", 32'({irq0, irq1}), 0);
      chk("rstmid_wren", 32'(mem_wren), 0);
      chk("rstmid_ack", 32'(vid_ack), 0);
      host_csx = 1'b1; host_rdx = 1'b1;
      step(); step();
      resetx = 1'b1;
      ref_bank = 1'b0;
      $display("reset mid-access, pending video write follows");
      vid_write(15'h0044, 16'h7777, -1);
    end

    // random mix against the reference memory image
    for (int n = 0; n < 80; n++) begin
      a = 15'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: vid_write(a, 16'($urandom), 1);
        1: host_read(a, 5);
        2: host_write(a, 16'($urandom));
        default: frame_end_op();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
